lcd_ctrl_param: RTL and testbench
=================================

Name: lcd_ctrl_param

Overview:
- Parametrised successor of the team's 8x8 LCD image controller.
- Loads an IMG_W x IMG_W image of DW-bit pixels from IROM into an internal buffer.
- Executes host commands on a movable 2x2 operation window: shift, max, min, average, rotate, mirror.
- On the write command, dumps the buffer to IRAM, then asserts done. Sits between the host command interface and the IROM/IRAM image memories.

Parameters:
- DW, 8, pixel width in bits.
- LOG_W, 3, log2 of image side. IMG_W = 2**LOG_W (minimum 4). N = IMG_W*IMG_W pixels. AW = 2*LOG_W address bits (derived localparams).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  command code.
- cmd_valid  in  1  cmd qualifier.
- IROM_Q  in  DW  ROM read data; combinational, valid in the same cycle as IROM_A.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  AW  ROM address.
- IRAM_valid  out  1  RAM write strobe.
- IRAM_D  out  DW  RAM write data.
- IRAM_A  out  AW  RAM write address.
- busy  out  1  high = commands not accepted.
- done  out  1  image fully written.

Behaviour:
- All outputs are registered. Reset values: IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0, state=LOAD, window origin (x,y)=(IMG_W/2-1, IMG_W/2-1). The buffer is not cleared.
- States: LOAD -> IDLE -> OP -> IDLE ..., or IDLE -> WRITE -> DONE. Only reset leaves DONE.
- LOAD:
  - IROM_rd=1 from the first cycle after reset release.
  - Every edge with IROM_rd=1 stores buf[IROM_A] <= IROM_Q and increments IROM_A.
  - The edge that captures address N-1 drops IROM_rd, returns IROM_A to 0, drops busy and enters IDLE. Load takes exactly N cycles.
- IDLE: busy=0. A command is accepted on an edge with cmd_valid=1 and busy=0. cmd_valid while busy=1 is ignored, not queued.
- OP, for accepted cmd 1-15:
  - busy=1 for exactly one cycle, in which the operation commits to buf / origin. Return to IDLE.
  - Back-to-back commands are therefore accepted at most every 2 cycles.
- Window: a=(x,y), b=(x+1,y), c=(x,y+1), d=(x+1,y+1). Address = y*IMG_W+x.
- Commands:
  - 0 write.
  - 1 up (y-1), 2 down (y+1), 3 left (x-1), 4 right (x+1). Each saturates at 0 / IMG_W-2: an out-of-range shift leaves the origin unchanged and still costs the OP cycle.
  - 5 max: all four pixels <= max(a,b,c,d).
  - 6 min: all four pixels <= min(a,b,c,d).
  - 7 avg: all four pixels <= (a+b+c+d)>>2, summed at DW+2 bits, floor, no overflow.
  - 8 rotate CCW: a<=b, b<=d, d<=c, c<=a.
  - 9 rotate CW: a<=c, c<=d, d<=b, b<=a.
  - 10 mirror X: a<->c, b<->d.
  - 11 mirror Y: a<->b, c<->d.
  - 12-15 no-op: one busy cycle, no change.
  - All four pixel updates use pre-operation values, written simultaneously.
- WRITE, entered on accepted cmd 0:
  - busy stays 1.
  - From the next cycle, IRAM_valid=1 with IRAM_A=k, IRAM_D=buf[k] for k=0..N-1 on consecutive cycles, i.e. N cycles.
  - The cycle after k=N-1: IRAM_valid=0, IRAM_A=0, done=1, enter DONE.
- DONE: done=1 and busy=1 held until reset. cmd ignored.
- Reset asserted mid-LOAD/OP/WRITE: immediate return to reset values. The write sequence is abandoned and the next run reloads the image from address 0.

Test Plan:
- DW=8, LOG_W=3, IROM[i]=i; release reset -> IROM_rd high exactly 64 cycles, IROM_A 0..63, busy falls on the 64th edge; cmd 0 -> IRAM writes D=A for A=0..63, then done=1, busy=1.
- Boundaries: from (3,3), 4x cmd 3 then 4x cmd 1 -> origin (0,0), with the 4th shift in each direction a no-op; 7x cmd 4 -> x=6, further cmd 4 keeps x=6; dump confirms pixel contents untouched.
- Arithmetic at origin (3,3) with a=27, b=28, c=35, d=36: cmd 5 -> all 36; reload, cmd 6 -> all 27; reload, cmd 7 -> all 31 (126>>2); with pixels 255,255,255,254, cmd 7 -> 254.
- Geometry at origin (3,3) with a=27, b=28, c=35, d=36: cmd 8 -> (28,36,27,35); cmd 9 -> (35,27,36,28); cmd 10 -> (35,36,27,28); cmd 11 -> (28,27,36,35); each verified via dump at IRAM_A 27, 28, 35, 36.
- Handshake: cmd_valid held high with cmd=4 for 6 cycles -> exactly 3 accepted, busy alternates 1/0; cmd 13 -> one busy cycle, dump identical to input.
- Reset at IRAM_A=20 during WRITE -> IRAM_valid=0 and done=0 immediately, full 64-cycle reload follows; repeat the first scenario with LOG_W=4, DW=10 -> 256-cycle load/dump, initial origin (7,7).

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// ---------------------------------------------------------------------------
// lcd_ctrl_param
//
// Parametrised LCD image controller. After reset it streams an IMG_W x IMG_W
// image of DW-bit pixels out of IROM into an internal pixel buffer, then
// serves host commands that act on a movable 2x2 operation window (shift,
// max, min, average, rotate, mirror). The write command dumps the whole
// buffer to IRAM and then raises done, which holds until reset.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   reset      : asynchronous, active-high reset
//   cmd        : 4-bit command code
//   cmd_valid  : qualifies cmd; taken only while busy is low
//   IROM_Q     : ROM read data, combinational on IROM_A
//   IROM_rd    : ROM read enable
//   IROM_A     : ROM address
//   IRAM_valid : RAM write strobe
//   IRAM_D     : RAM write data
//   IRAM_A     : RAM write address
//   busy       : high while commands are not accepted
//   done       : image has been fully written to IRAM
//
// Window layout at origin (x,y): a=(x,y) b=(x+1,y) c=(x,y+1) d=(x+1,y+1),
// pixel address = y*IMG_W + x.
// ---------------------------------------------------------------------------
module lcd_ctrl_param #(
  parameter int DW    = 8,
  parameter int LOG_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           cmd,
  input  logic                 cmd_valid,
  input  logic [DW-1:0]        IROM_Q,
  output logic                 IROM_rd,
  output logic [2*LOG_W-1:0]   IROM_A,
  output logic                 IRAM_valid,
  output logic [DW-1:0]        IRAM_D,
  output logic [2*LOG_W-1:0]   IRAM_A,
  output logic                 busy,
  output logic                 done
);

  localparam int IMG_W = 1 << LOG_W;
  localparam int N     = IMG_W * IMG_W;
  localparam int AW    = 2 * LOG_W;

  localparam logic [LOG_W-1:0] ORG_MAX  = LOG_W'(IMG_W - 2);
  localparam logic [LOG_W-1:0] ORG_INIT = LOG_W'(IMG_W / 2 - 1);
  localparam logic [AW-1:0]    LAST_A   = AW'(N - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_OP,
    S_WRITE,
    S_DONE
  } state_t;

  // -------------------------------------------------------------------------
  // Pixel helpers
  // -------------------------------------------------------------------------
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] p,
                                         input logic [DW-1:0] q);
    return (p > q) ? p : q;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] p,
                                         input logic [DW-1:0] q);
    return (p < q) ? p : q;
  endfunction

  // Two guard bits hold the sum of four pixels; dropping the two LSBs is
  // the floor of the mean.
  function automatic logic [DW-1:0] avg4(input logic [DW-1:0] p0,
                                         input logic [DW-1:0] p1,
                                         input logic [DW-1:0] p2,
                                         input logic [DW-1:0] p3);
    logic [DW+1:0] sum;
    sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    return sum[DW+1:2];
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_q;
  logic              rom_rd_q;
  logic [AW-1:0]     rom_a_q;
  logic              ram_v_q;
  logic [DW-1:0]     ram_d_q;
  logic [AW-1:0]     ram_a_q;
  logic              busy_q;
  logic              done_q;
  logic [LOG_W-1:0]  ox_q;
  logic [LOG_W-1:0]  oy_q;
  logic [3:0]        op_q;

  // Pixel buffer: pure data, never reset.
  logic [DW-1:0]     img_q [N];

  // -------------------------------------------------------------------------
  // Window addressing and operation results
  // -------------------------------------------------------------------------
  logic [AW-1:0]     addr_a, addr_b, addr_c, addr_d;
  logic [DW-1:0]     pa, pb, pc, pd;
  logic [DW-1:0]     pix_a_d, pix_b_d, pix_c_d, pix_d_d;
  logic              pix_we;
  logic [DW-1:0]     wmax, wmin, wavg;
  logic [AW-1:0]     dump_addr;

  // The origin never exceeds IMG_W-2, so x+1 / y+1 never wrap.
  assign addr_a = {oy_q, ox_q};
  assign addr_b = {oy_q, ox_q + LOG_W'(1)};
  assign addr_c = {oy_q + LOG_W'(1), ox_q};
  assign addr_d = {oy_q + LOG_W'(1), ox_q + LOG_W'(1)};

  assign pa = img_q[addr_a];
  assign pb = img_q[addr_b];
  assign pc = img_q[addr_c];
  assign pd = img_q[addr_d];

  assign wmax = max2(max2(pa, pb), max2(pc, pd));
  assign wmin = min2(min2(pa, pb), min2(pc, pd));
  assign wavg = avg4(pa, pb, pc, pd);

  // All four new values derive from the pre-operation window so that the
  // rotations and mirrors commit atomically on one edge.
  always_comb begin
    pix_a_d = pa;
    pix_b_d = pb;
    pix_c_d = pc;
    pix_d_d = pd;
    pix_we  = 1'b0;
    if (state_q == S_OP) begin
      case (op_q)
        4'd5: begin
          pix_a_d = wmax; pix_b_d = wmax; pix_c_d = wmax; pix_d_d = wmax;
          pix_we  = 1'b1;
        end
        4'd6: begin
          pix_a_d = wmin; pix_b_d = wmin; pix_c_d = wmin; pix_d_d = wmin;
          pix_we  = 1'b1;
        end
        4'd7: begin
          pix_a_d = wavg; pix_b_d = wavg; pix_c_d = wavg; pix_d_d = wavg;
          pix_we  = 1'b1;
        end
        4'd8: begin   // rotate counter-clockwise
          pix_a_d = pb; pix_b_d = pd; pix_d_d = pc; pix_c_d = pa;
          pix_we  = 1'b1;
        end
        4'd9: begin   // rotate clockwise
          pix_a_d = pc; pix_c_d = pd; pix_d_d = pb; pix_b_d = pa;
          pix_we  = 1'b1;
        end
        4'd10: begin  // mirror about the horizontal axis
          pix_a_d = pc; pix_c_d = pa; pix_b_d = pd; pix_d_d = pb;
          pix_we  = 1'b1;
        end
        4'd11: begin  // mirror about the vertical axis
          pix_a_d = pb; pix_b_d = pa; pix_c_d = pd; pix_d_d = pc;
          pix_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next dump address: 0 on the first write cycle, then sequential.
  assign dump_addr = ram_v_q ? (ram_a_q + AW'(1)) : '0;

  // -------------------------------------------------------------------------
  // Pixel buffer write port (image load and window operations)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && rom_rd_q) begin
      img_q[rom_a_q] <= IROM_Q;
    end else if (pix_we) begin
      img_q[addr_a] <= pix_a_d;
      img_q[addr_b] <= pix_b_d;
      img_q[addr_c] <= pix_c_d;
      img_q[addr_d] <= pix_d_d;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      rom_rd_q <= 1'b0;
      rom_a_q  <= '0;
      ram_v_q  <= 1'b0;
      ram_d_q  <= '0;
      ram_a_q  <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      ox_q     <= ORG_INIT;
      oy_q     <= ORG_INIT;
      op_q     <= 4'd0;
    end else begin
      case (state_q)
        S_LOAD: begin
          // The first cycle after reset only raises the read enable; each
          // following edge captures one pixel.
          if (!rom_rd_q) begin
            rom_rd_q <= 1'b1;
          end else if (rom_a_q == LAST_A) begin
            rom_rd_q <= 1'b0;
            rom_a_q  <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            rom_a_q  <= rom_a_q + AW'(1);
          end
        end

        S_IDLE: begin
          if (cmd_valid && !busy_q) begin
            busy_q <= 1'b1;
            if (cmd == 4'd0) begin
              state_q <= S_WRITE;
            end else begin
              op_q    <= cmd;
              state_q <= S_OP;
            end
          end
        end

        S_OP: begin
          // Pixel commands commit in the buffer block on this same edge.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          case (op_q)
            4'd1: if (oy_q != '0)      oy_q <= oy_q - LOG_W'(1);
            4'd2: if (oy_q != ORG_MAX) oy_q <= oy_q + LOG_W'(1);
            4'd3: if (ox_q != '0)      ox_q <= ox_q - LOG_W'(1);
            4'd4: if (ox_q != ORG_MAX) ox_q <= ox_q + LOG_W'(1);
            default: ;
          endcase
        end

        S_WRITE: begin
          if (ram_v_q && ram_a_q == LAST_A) begin
            ram_v_q <= 1'b0;
            ram_a_q <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ram_v_q <= 1'b1;
            ram_a_q <= dump_addr;
            ram_d_q <= img_q[dump_addr];
          end
        end

        S_DONE: begin
          busy_q <= 1'b1;
          done_q <= 1'b1;
        end

        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign IROM_rd    = rom_rd_q;
  assign IROM_A     = rom_a_q;
  assign IRAM_valid = ram_v_q;
  assign IRAM_D     = ram_d_q;
  assign IRAM_A     = ram_a_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
module tb_lcd_ctrl_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;

  // 8x8 image, 8-bit pixels
  logic [7:0] q1;
  logic       rd1, v1, busy1, done1;
  logic [5:0] ra1, wa1;
  logic [7:0] d1;

  // 16x16 image, 10-bit pixels
  logic [9:0] q2;
  logic       rd2, v2, busy2, done2;
  logic [7:0] ra2, wa2;
  logic [9:0] d2;

  logic [7:0] rom1 [64];
  logic [9:0] rom2 [256];

  assign q1 = rom1[ra1];
  assign q2 = rom2[ra2];

  always #5 clk = ~clk;

  lcd_ctrl_param #(.DW(8), .LOG_W(3)) dut1 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(q1), .IROM_rd(rd1), .IROM_A(ra1),
    .IRAM_valid(v1), .IRAM_D(d1), .IRAM_A(wa1),
    .busy(busy1), .done(done1)
  );

  lcd_ctrl_param #(.DW(10), .LOG_W(4)) dut2 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(q2), .IROM_rd(rd2), .IROM_A(ra2),
    .IRAM_valid(v2), .IRAM_D(d2), .IRAM_A(wa2),
    .busy(busy2), .done(done2)
  );

  // Observation mux: sel=0 watches the 8x8 instance, sel=1 the 16x16 one.
  int         sel = 0;
  logic       o_rd, o_v, o_busy, o_done;
  logic [7:0] o_ra, o_wa;
  logic [9:0] o_d;
  assign o_rd   = (sel != 0) ? rd2   : rd1;
  assign o_v    = (sel != 0) ? v2    : v1;
  assign o_busy = (sel != 0) ? busy2 : busy1;
  assign o_done = (sel != 0) ? done2 : done1;
  assign o_ra   = (sel != 0) ? ra2   : {2'b00, ra1};
  assign o_wa   = (sel != 0) ? wa2   : {2'b00, wa1};
  assign o_d    = (sel != 0) ? d2    : {2'b00, d1};

  int tests = 0;
  int errs  = 0;

  // Reference model: image as a flat array, origin as plain integers.
  int mimg [256];
  int mx, my, mw, mn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_rom(input int rnd);
    for (int i = 0; i < 64; i++)  rom1[i] = (rnd != 0) ? 8'($urandom_range(0, 255)) : 8'(i);
    for (int i = 0; i < 256; i++) rom2[i] = (rnd != 0) ? 10'($urandom_range(0, 1023)) : 10'(i);
  endtask

  task automatic load_model();
    mw = (sel != 0) ? 16 : 8;
    mn = mw * mw;
    for (int i = 0; i < mn; i++) mimg[i] = (sel != 0) ? int'(rom2[i]) : int'(rom1[i]);
    mx = mw / 2 - 1;
    my = mw / 2 - 1;
  endtask

  task automatic apply_model(input int c);
    int ia, ib, ic, id, a, b, cc, d, m;
    ia = my * mw + mx; ib = ia + 1; ic = ia + mw; id = ic + 1;
    a = mimg[ia]; b = mimg[ib]; cc = mimg[ic]; d = mimg[id];
    case (c)
      1: if (my > 0) my--;
      2: if (my < mw - 2) my++;
      3: if (mx > 0) mx--;
      4: if (mx < mw - 2) mx++;
      5: begin
        m = a; if (b > m) m = b; if (cc > m) m = cc; if (d > m) m = d;
        mimg[ia] = m; mimg[ib] = m; mimg[ic] = m; mimg[id] = m;
      end
      6: begin
        m = a; if (b < m) m = b; if (cc < m) m = cc; if (d < m) m = d;
        mimg[ia] = m; mimg[ib] = m; mimg[ic] = m; mimg[id] = m;
      end
      7: begin
        m = (a + b + cc + d) / 4;
        mimg[ia] = m; mimg[ib] = m; mimg[ic] = m; mimg[id] = m;
      end
      8:  begin mimg[ia] = b;  mimg[ib] = d;  mimg[id] = cc; mimg[ic] = a; end
      9:  begin mimg[ia] = cc; mimg[ic] = d;  mimg[id] = b;  mimg[ib] = a; end
      10: begin mimg[ia] = cc; mimg[ic] = a;  mimg[ib] = d;  mimg[id] = b; end
      11: begin mimg[ia] = b;  mimg[ib] = a;  mimg[ic] = d;  mimg[id] = cc; end
      default: ;
    endcase
  endtask

  task automatic load_check();
    int k;
    bit seen;
    k = 0; seen = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (o_rd) begin
        chk("rom_addr", o_ra, k);
        k++; seen = 1;
      end else if (seen) begin
        break;
      end
    end
    chk("load_len", k, mn);
    chk("busy_after_load", o_busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 1);
    chk("rst_rd", o_rd, 0);
    chk("rst_rom_a", o_ra, 0);
    chk("rst_valid", o_v, 0);
    chk("rst_ram_a", o_wa, 0);
    chk("rst_ram_d", o_d, 0);
    chk("rst_done", o_done, 0);
    reset = 1'b0;
    load_model();
    load_check();
  endtask

  task automatic send_cmd(input int c);
    int w;
    w = 0;
    while (o_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (o_busy) begin
      chk("idle_timeout", o_busy, 0);
      return;
    end
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_accept", o_busy, 1);
    if (c != 0) begin
      @(negedge clk);
      chk("busy_op_end", o_busy, 0);
      apply_model(c);
    end
  endtask

  task automatic dump();
    int k;
    bit started;
    send_cmd(0);
    k = 0; started = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (o_v) begin
        chk("dump_addr", o_wa, k);
        chk("dump_data", o_d, mimg[k % 256]);
        k++; started = 1;
      end else if (started) begin
        break;
      end
    end
    chk("dump_len", k, mn);
    chk("done_set", o_done, 1);
    chk("done_busy", o_busy, 1);
    chk("done_ram_a", o_wa, 0);
  endtask

  initial begin
    // Plain load and dump of an identity image.
    sel = 0;
    fill_rom(0);
    do_reset();
    dump();
    // DONE is sticky and ignores commands.
    cmd = 4'd4; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    chk("done_hold", o_done, 1);
    chk("done_hold_busy", o_busy, 1);

    // Origin saturation at the top-left corner, revealed by a max op.
    do_reset();
    repeat (4) send_cmd(3);
    repeat (4) send_cmd(1);
    send_cmd(5);
    dump();

    // Saturation at the right edge, revealed by a min op.
    do_reset();
    repeat (7) send_cmd(4);
    send_cmd(4);
    send_cmd(6);
    dump();

    // Arithmetic and geometry at the initial origin.
    for (int c = 5; c <= 11; c++) begin
      do_reset();
      send_cmd(c);
      dump();
    end

    // Average must not overflow on near-full-scale pixels.
    fill_rom(1);
    rom1[27] = 8'd255; rom1[28] = 8'd255; rom1[35] = 8'd255; rom1[36] = 8'd254;
    do_reset();
    send_cmd(7);
    dump();

    // cmd_valid held high: accepted every second cycle.
    fill_rom(0);
    do_reset();
    cmd = 4'd4; cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hs_busy", o_busy, (i % 2 == 0) ? 1 : 0);
    end
    cmd_valid = 1'b0;
    repeat (3) apply_model(4);
    send_cmd(13);
    send_cmd(5);
    dump();

    // Random images and command streams.
    for (int r = 0; r < 4; r++) begin
      fill_rom(1);
      do_reset();
      for (int j = 0; j < 30; j++) send_cmd(int'($urandom_range(1, 15)));
      dump();
    end

    // Reset in the middle of a dump.
    fill_rom(1);
    do_reset();
    send_cmd(2);
    send_cmd(9);
    send_cmd(0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (o_v && o_wa == 8'd20) break;
    end
    chk("wr_reach20", o_wa, 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", o_v, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_busy", o_busy, 1);
    fill_rom(1);
    do_reset();
    send_cmd(8);
    dump();

    // Larger geometry: 16x16 image with 10-bit pixels.
    sel = 1;
    fill_rom(0);
    do_reset();
    dump();
    do_reset();
    send_cmd(7);
    send_cmd(4);
    send_cmd(5);
    dump();
    fill_rom(1);
    do_reset();
    for (int j = 0; j < 30; j++) send_cmd(int'($urandom_range(1, 15)));
    dump();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
